// File: rtl/mad_unit_if.sv
// Bus between the E stage and the multiply/divide unit: operation start, HI/LO moves,
// operands, and the HI/LO/busy results.
interface mad_unit_if;
  logic        MAD_start;
  logic [2:0]  MAD_sel;
  logic        HI_En;
  logic        LO_En;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (
    output MAD_start, MAD_sel, HI_En, LO_En, A, B,
    input  HI, LO, busy
  );

  modport slave (
    input  MAD_start, MAD_sel, HI_En, LO_En, A, B,
    output HI, LO, busy
  );
endinterface

// File: rtl/mad_unit.sv
// Multi-cycle mult/multu/div/divu unit owning the HI/LO registers. A fixed-latency
// countdown emulates the iterative unit; results are written on the final RUN edge.
module mad_unit (
  input  logic        clk,
  input  logic        reset,
  mad_unit_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  op_t         op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy;

  // Selects 4..7 are reserved and never start anything.
  logic start_ok;
  assign start_ok = bus.MAD_start && !bus.MAD_sel[2];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // Result datapath, evaluated from the latched operands only.
  logic        is_signed_mul, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        write_res;

  always_comb begin
    is_signed_mul = (op_q == OP_MULT);
    prod = {{32{is_signed_mul & a_q[31]}}, a_q} * {{32{is_signed_mul & b_q[31]}}, b_q};

    // Signed divide via magnitudes; the sign fix-up gives truncation toward zero
    // and a remainder that follows the dividend.
    a_neg = (op_q == OP_DIV) && a_q[31];
    b_neg = (op_q == OP_DIV) && b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_hi = rem;
      res_lo = quot;
    end

    // A divide by zero completes with normal timing but leaves HI/LO alone.
    write_res = !(op_q[1] && (b_q == 32'd0));
  end

  // NOTE: operand/op latches carry no reset; they are always loaded on the start
  // edge before being consumed, so only the architecturally visible state resets.
  always_ff @(posedge clk) begin
    if (start_ok && state_q == IDLE && !reset) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= op_t'(bus.MAD_sel[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            cnt_q <= bus.MAD_sel[1] ? 4'd9 : 4'd4;
          end else begin
            if (bus.HI_En) hi_q <= bus.A;
            if (bus.LO_En) lo_q <= bus.A;
          end
        end
        RUN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (write_res) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: cnt_q <= 4'd0;
      endcase
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.busy = busy;

endmodule

// File: tb/tb_mad_unit.sv
// Self-checking bench for mad_unit: directed corner cases plus randomized operations
// compared against a 64-bit arithmetic reference model with a HI/LO scoreboard.
module tb_mad_unit;

  logic clk = 1'b0;
  logic reset;
  mad_unit_if bus ();

  mad_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MAD_start = 1'b0;
    bus.MAD_sel   = 3'd0;
    bus.HI_En     = 1'b0;
    bus.LO_En     = 1'b0;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
  endtask

  // Reference: {HI, LO} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input int sel, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (sel)
      0: begin p = sa * sb; return p; end
      1: begin p = ua * ub; return p; end
      2: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        p = {32'(ua % ub), 32'(ua / ub)};
        return p;
      end
    endcase
  endfunction

  task automatic wait_idle(output int n, input bit scramble);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      if (scramble) begin
        bus.A         = $urandom;
        bus.B         = $urandom;
        bus.MAD_sel   = 3'($urandom);
        bus.MAD_start = 1'($urandom);
        bus.HI_En     = 1'($urandom);
        bus.LO_En     = 1'($urandom);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic run_op(input string tag, input int sel, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit with_en);
    logic [63:0] r;
    int n;
    bus.MAD_start = 1'b1;
    bus.MAD_sel   = 3'(sel);
    bus.A         = a;
    bus.B         = b;
    bus.HI_En     = with_en;
    bus.LO_En     = with_en;
    tick();
    idle_inputs();
    check({tag, "_start_busy"}, bus.busy, 1);
    wait_idle(n, scramble);
    check({tag, "_busy_cycles"}, n, (sel >= 2) ? 10 : 5);
    r = model(sel, a, b, m_hi, m_lo);
    m_hi = r[63:32];
    m_lo = r[31:0];
    check({tag, "_hi"}, bus.HI, m_hi);
    check({tag, "_lo"}, bus.LO, m_lo);
  endtask

  task automatic move(input string tag, input bit hi_en, input bit lo_en, input logic [31:0] val);
    bus.HI_En = hi_en;
    bus.LO_En = lo_en;
    bus.A     = val;
    tick();
    idle_inputs();
    if (hi_en) m_hi = val;
    if (lo_en) m_lo = val;
    check({tag, "_hi"}, bus.HI, m_hi);
    check({tag, "_lo"}, bus.LO, m_lo);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    logic [63:0] r;

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_hi", bus.HI, 0);
    check("reset_lo", bus.LO, 0);

    run_op("mult", 0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    check("mult_hi_const", bus.HI, 64'hFFFF_FFFF);
    check("mult_lo_const", bus.LO, 64'hFFFF_FFFE);
    run_op("multu", 1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    check("multu_hi_const", bus.HI, 64'h0000_0001);
    check("multu_lo_const", bus.LO, 64'hFFFF_FFFE);
    run_op("div", 2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", bus.LO, 64'hFFFF_FFFD);
    check("div_hi_const", bus.HI, 64'hFFFF_FFFF);
    run_op("divu", 3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lo_const", bus.LO, 64'd3);
    check("divu_hi_const", bus.HI, 64'd1);
    run_op("div_min", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    move("mthi", 1'b1, 1'b0, 32'h1234_5678);
    move("mtlo", 1'b0, 1'b1, 32'h8765_4321);

    // HI_En while busy must be ignored.
    bus.MAD_start = 1'b1;
    bus.MAD_sel   = 3'd3;
    bus.A         = 32'd100;
    bus.B         = 32'd7;
    tick();
    idle_inputs();
    bus.HI_En = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    tick();
    bus.HI_En = 1'b0;
    check("mthi_busy_hi", bus.HI, m_hi);
    wait_idle(n, 1'b0);
    check("mthi_busy_cycles", n + 1, 10);
    r = model(3, 32'd100, 32'd7, m_hi, m_lo);
    m_hi = r[63:32];
    m_lo = r[31:0];
    check("mthi_busy_res_hi", bus.HI, m_hi);
    check("mthi_busy_res_lo", bus.LO, m_lo);

    // Divide by zero leaves HI/LO untouched.
    move("pre_dz_hi", 1'b1, 1'b0, 32'h0000_AAAA);
    move("pre_dz_lo", 1'b0, 1'b1, 32'h0000_5555);
    run_op("divu_by0", 3, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("divu_by0_hi_const", bus.HI, 64'hAAAA);
    check("divu_by0_lo_const", bus.LO, 64'h5555);
    run_op("div_by0", 2, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0);

    // Start together with HI_En/LO_En: start only.
    run_op("start_en", 0, 32'd3, 32'd5, 1'b0, 1'b1);

    // Reserved selects never start.
    for (int s = 4; s < 8; s++) begin
      bus.MAD_start = 1'b1;
      bus.MAD_sel   = 3'(s);
      bus.A         = 32'd9;
      bus.B         = 32'd3;
      tick();
      idle_inputs();
      check($sformatf("reserved_%0d_busy", s), bus.busy, 0);
      check($sformatf("reserved_%0d_hi", s), bus.HI, m_hi);
    end

    // Scrambled inputs during RUN, then a back-to-back start.
    run_op("scr_mult", 0, 32'hC000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("b2b_div", 2, 32'hFFFF_FF00, 32'd7, 1'b1, 1'b0);
    run_op("b2b_multu", 1, 32'h0001_0001, 32'hFFFF_0000, 1'b0, 1'b0);

    // Reset in the 3rd cycle of a divide aborts it.
    move("pre_rst", 1'b1, 1'b1, 32'h1111_1111);
    bus.MAD_start = 1'b1;
    bus.MAD_sel   = 3'd2;
    bus.A         = 32'hFFFF_FF9C;
    bus.B         = 32'd3;
    tick();
    idle_inputs();
    tick();
    tick();
    check("rst_mid_busy_before", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_hi", bus.HI, 0);
    check("rst_mid_lo", bus.LO, 0);
    repeat (12) tick();
    check("rst_late_hi", bus.HI, 0);
    check("rst_late_lo", bus.LO, 0);
    check("rst_late_busy", bus.busy, 0);

    // Randomized operations with occasional HI/LO moves and small/zero divisors.
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [31:0] a, b;
      sel = int'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0)
        move($sformatf("rnd%0d_mv", i), 1'($urandom), 1'($urandom), $urandom);
      run_op($sformatf("rnd%0d", i), sel, a, b, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected summary before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mad_unit.md
MAD_UNIT -- requirements
Module: mad_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port MAD_start, input, 1 bit: the E-stage instruction is mult/multu/div/divu; start an operation.
REQ-004 SHALL have port MAD_sel, input, 3 bits: operation select; 0 mult, 1 multu, 2 div, 3 divu, 4-7 reserved.
REQ-005 SHALL have port HI_En, input, 1 bit: mthi; write A to HI.
REQ-006 SHALL have port LO_En, input, 1 bit: mtlo; write A to LO.
REQ-007 SHALL have port A, input, 32 bits: forwarded rs value from E stage.
REQ-008 SHALL have port B, input, 32 bits: forwarded rt value from E stage.
REQ-009 SHALL have port HI, output, 32 bits: HI register, read by mfhi.
REQ-010 SHALL have port LO, output, 32 bits: LO register, read by mflo.
REQ-011 SHALL have port busy, output, 1 bit: an operation is in flight; the hazard unit stalls D-stage instructions with ifMAD while (busy | MAD_start).

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, with a 4-bit down-counter cnt; busy = (state==RUN).
REQ-013 SHALL, in IDLE, on an edge where MAD_start=1 and MAD_sel is 0..3: latch A, B and MAD_sel into internal registers, load cnt with 4 for mult/multu or 9 for div/divu, and enter RUN.
REQ-014 SHALL, in RUN, decrement cnt on each edge while cnt>0; on the edge where cnt==0, write the results to HI/LO and return to IDLE.
REQ-015 SHALL therefore hold busy high for exactly 5 cycles for mult/multu and exactly 10 cycles for div/divu after the start edge; results SHALL be visible on HI/LO in the first cycle in which busy=0.
REQ-016 SHALL compute mult as the signed 64-bit product A*B and multu as the unsigned 64-bit product, with HI = product[63:32] and LO = product[31:0].
REQ-017 SHALL compute div with signed operands, LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; divu SHALL produce the unsigned quotient in LO and the unsigned remainder in HI.
REQ-018 SHALL NOT modify HI or LO on completion of div/divu with latched B==0; the busy timing SHALL be unchanged in that case.
REQ-019 SHALL use the latched operands only; changes on A/B/MAD_sel during RUN SHALL NOT affect the result.
REQ-020 SHALL, in IDLE, write A to HI on an edge where HI_En=1 and write A to LO on an edge where LO_En=1; HI and LO SHALL update on that same edge.
REQ-021 SHALL ignore MAD_start, HI_En and LO_En during RUN.
REQ-022 SHALL, when MAD_start and HI_En/LO_En are both high in IDLE, perform the start only and not the HI/LO write.
REQ-023 SHALL ignore MAD_start when MAD_sel is 4..7: the FSM stays in IDLE and busy stays 0.
REQ-024 SHALL start an operation on the edge immediately following completion when MAD_start=1 in that first IDLE cycle, i.e. back-to-back operations with no gap cycle.

Reset
REQ-025 SHALL, on an edge with reset=1, set HI=0, LO=0, cnt=0 and state=IDLE (busy=0), aborting any operation in flight without writing its results; reset SHALL take priority over all other inputs.

Verification
REQ-026 SHALL cover: mult with A=0xFFFFFFFF, B=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-027 SHALL cover: div with A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-028 SHALL cover: mthi with A=0x12345678 -> HI=0x12345678 on the next edge with busy=0; HI_En asserted while busy -> HI unchanged.
REQ-029 SHALL cover: with HI=0xAAAA, LO=0x5555, divu with B=0 -> busy high 10 cycles, then HI=0xAAAA, LO=0x5555.
REQ-030 SHALL cover: reset asserted in the 3rd cycle of a div -> busy=0, HI=0, LO=0 on the next edge; no later write occurs.
REQ-031 SHALL cover: A and B changed every cycle during RUN, plus MAD_start asserted in the first cycle after completion -> first result correct, and the second operation starts with no gap cycle.
